cdc_toggle_tx: RTL and testbench
================================

Name: cdc_toggle_tx

Overview:
- Source-side transmitter for the toggle-handshake CDC link; the far-end receiver runs in another clock domain.
- Accepts words on a valid/ready interface and buffers them in a small FIFO.
- Launches one word at a time by holding tx_data stable and flipping tx_req.
- Waits for the receiver's returned acknowledge toggle, synchronised internally, before launching the next word.

Parameters:
- DATA_WIDTH, 8: width of in_data and tx_data.
- FIFO_DEPTH, 4: input buffer entries; power of two, >= 2.
- SYNC_STAGES, 2: flops in the tx_ack synchroniser; >= 2.

Ports:
- clk  in  1  single clock for all logic in this block.
- rst_n  in  1  asynchronous active-low reset; async assert, release synchronised upstream.
- in_data  in  DATA_WIDTH  word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- tx_data  out  DATA_WIDTH  word presented to the far domain; registered.
- tx_req  out  1  request toggle; flips once per launched word; registered.
- tx_ack  in  1  acknowledge toggle from the receiver; asynchronous to clk.
- busy  out  1  word in flight or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- proto_err  out  1  sticky flag for an unsolicited ack toggle.

Behaviour:
- **Reset** (rst_n low, any time, including mid-transfer): FIFO emptied, fifo_count=0, state=IDLE, tx_data=0, tx_req=0, all sync flops=0, proto_err=0, busy=0. in_ready=0 while rst_n is low and 1 from the first edge after release. The receiver shares this reset, so its ack toggle also returns to 0.
- **Push:** a word is written when in_valid && in_ready at a rising edge. in_ready = (fifo_count < FIFO_DEPTH), combinational from registered count. Pointers wrap modulo FIFO_DEPTH. Words are launched in FIFO order.
- **Full FIFO:** in_ready=0, and a pop in the same cycle does not enable a push. in_ready rises the cycle after the pop.
- **Ack synchroniser:** tx_ack shifts through a SYNC_STAGES-flop chain; ack_s is the last stage. No other logic samples tx_ack.
- **State IDLE:**
  - If the FIFO is non-empty at an edge: pop the head into tx_data, tx_req <= ~tx_req, go to WAIT_ACK.
  - If ack_s != tx_req while in IDLE: set proto_err. It stays set until reset; operation otherwise continues.
- **State WAIT_ACK:**
  - tx_data and tx_req are held constant. Pushes are still accepted.
  - When ack_s == tx_req, the transfer is complete. If the FIFO is non-empty, pop the next word and flip tx_req at that same edge (back-to-back, no IDLE cycle). Otherwise go to IDLE.
- **Push and pop at the same edge:** fifo_count is unchanged; both operations take effect.
- **Push into an empty FIFO while IDLE:** no bypass. The word is written at edge E0 and launched at E1, so tx_req flips 1 cycle after acceptance.
- **Round trip:** tx_ack toggling before edge k gives ack_s at edge k+SYNC_STAGES-1. Completion and any next launch occur at edge k+SYNC_STAGES-1 (the same edge).
- **Throughput:** at most one word per handshake round trip; no words are dropped or duplicated.
- **busy** = (state==WAIT_ACK) || (fifo_count != 0).

Test Plan:
1. Reset, then push 0xA5 with tx_ack looped back through 3 clk delay. Required: tx_req 0->1 one cycle after acceptance with tx_data=0xA5; tx_data stable until ack_s matches; then busy=0 and fifo_count=0.
2. Push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with tx_ack held. Required: in_ready drops once fifo_count=4 (0x01 launched, 0x02-0x05 buffered). Toggle tx_ack once: launch of 0x02 at the same edge ack_s matches, tx_req back to 0, in_ready=1 the next cycle.
3. Continuous stream of 0x10..0x1F with an auto-ack receiver. Required: the receiver captures exactly 16 words in order; tx_req toggles 16 times and ends at 0; proto_err=0.
4. While IDLE with tx_req=0, toggle tx_ack to 1. Required: proto_err=1 within SYNC_STAGES+1 cycles and still 1 after further normal transfers.
5. Assert rst_n low mid-WAIT_ACK with 3 words buffered. Required: immediately fifo_count=0, tx_req=0, tx_data=0, busy=0, proto_err=0. After release, a new word 0x7E transfers normally.
6. SYNC_STAGES=3, single word. Required: completion occurs exactly 3 edges after tx_ack toggles (ack sampled at edge k), i.e. at edge k+2, not earlier.

Source files
------------

// File: rtl/cdc_toggle_tx.sv
// cdc_toggle_tx: source side of a toggle-handshake CDC link.
// Words come in on a valid/ready port and are queued in a small FIFO.
// Each word is launched by holding tx_data and flipping tx_req. The next
// word waits until the receiver's ack toggle, brought in through a
// synchroniser, matches tx_req.
module cdc_toggle_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_req,
  input  logic                          tx_ack,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   ack_next;
  logic [0:0]             state;
  logic                   running;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   done;

  // ack_s is the fully synchronised ack. The FSM decides on the value
  // entering that last stage, so a transfer completes (and the next word
  // launches) on the same edge at which ack_s takes the matching value.
  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_next = ack_sync[SYNC_STAGES-2];

  // A full FIFO refuses a push even if a pop happens on the same edge.
  // Ready stays low until the first edge after reset release.
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = running && (fifo_count < CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign done       = (state == WAIT_ACK) && (ack_next == tx_req);
  assign pop        = !fifo_empty && ((state == IDLE) || done);
  assign busy       = (state == WAIT_ACK) || !fifo_empty;

  // Bring the asynchronous ack toggle into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
    end
  end

  // Flag that enables in_ready from the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  // FIFO storage. No reset is needed because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Launch and complete handshakes. Back-to-back launches skip IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_data <= '0;
      tx_req  <= 1'b0;
    end else begin
      if (pop) begin
        tx_data <= mem[rd_ptr];
        tx_req  <= ~tx_req;
        state   <= WAIT_ACK;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end

  // Sticky error when the ack moves while nothing is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if ((state == IDLE) && (ack_s != tx_req)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// Testbench for cdc_toggle_tx. It checks against a queue-based transaction
// model on every cycle and adds directed checks with literal expectations.
module tb_cdc_toggle_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          tx_ack;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          proto_err;

  logic [DW-1:0] in_data3;
  logic          in_valid3;
  logic          in_ready3;
  logic [DW-1:0] tx_data3;
  logic          tx_req3;
  logic          tx_ack3;
  logic          busy3;
  logic [2:0]    fifo_count3;
  logic          proto_err3;

  logic          loop_en;
  logic          manual_ack;
  logic [2:0]    loop_pipe;
  logic          rx_last_req;
  logic [DW-1:0] rx_q [$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: queue contents, word in flight, launch count, past ack samples.
  logic [DW-1:0] m_q [$];
  bit            m_inflight;
  int            m_launches;
  logic [DW-1:0] m_data;
  bit            m_proto;
  bit            m_ready;
  logic          m_ack_past [SYNC];
  bit            m_req;
  bit            m_push;
  bit            m_done;
  bit            m_launch;

  cdc_toggle_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .busy       (busy),
    .fifo_count (fifo_count),
    .proto_err  (proto_err)
  );

  cdc_toggle_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data3),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .tx_data    (tx_data3),
    .tx_req     (tx_req3),
    .tx_ack     (tx_ack3),
    .busy       (busy3),
    .fifo_count (fifo_count3),
    .proto_err  (proto_err3)
  );

  assign tx_ack = loop_en ? loop_pipe[2] : manual_ack;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Receiver: capture each new word on a req toggle, return ack three clk later.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      loop_pipe   = '0;
      rx_last_req = 1'b0;
    end else begin
      if (tx_req != rx_last_req) begin
        rx_q.push_back(tx_data);
        rx_last_req = tx_req;
      end
      loop_pipe = {loop_pipe[1:0], tx_req};
    end
  end

  // Transaction model: an ack sampled at edge k finishes the transfer at k+SYNC-1.
  // The idle-error check uses the ack one edge older than that.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 0;
      m_launches = 0;
      m_data     = '0;
      m_proto    = 0;
      m_ready    = 0;
      for (int j = 0; j < SYNC; j++) m_ack_past[j] = 1'b0;
    end else begin
      m_req    = m_launches[0];
      m_push   = in_valid && m_ready && (m_q.size() < DEPTH);
      m_done   = m_inflight && (m_ack_past[SYNC-2] == m_req);
      m_launch = (m_q.size() != 0) && (!m_inflight || m_done);
      if (!m_inflight && (m_ack_past[SYNC-1] != m_req)) m_proto = 1;
      if (m_launch) begin
        m_data = m_q.pop_front();
        m_launches++;
        m_inflight = 1;
      end else if (m_done) begin
        m_inflight = 0;
      end
      if (m_push) m_q.push_back(in_data);
      for (int j = SYNC - 1; j > 0; j--) m_ack_past[j] = m_ack_past[j-1];
      m_ack_past[0] = tx_ack;
      m_ready = 1;
    end
  end

  // Compare the DUT outputs with the model shortly after every rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    checkOutput("model_in_ready",   32'(in_ready),   32'(m_ready && (m_q.size() < DEPTH)));
    checkOutput("model_tx_data",    32'(tx_data),    32'(m_data));
    checkOutput("model_tx_req",     32'(tx_req),     32'(m_launches[0]));
    checkOutput("model_busy",       32'(busy),       32'(m_inflight || (m_q.size() != 0)));
    checkOutput("model_fifo_count", 32'(fifo_count), 32'(m_q.size()));
    checkOutput("model_proto_err",  32'(proto_err),  32'(m_proto));
  end

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    loop_en    = 1'b0;
    manual_ack = 1'b0;
    tx_ack3    = 1'b0;
    in_valid   = 1'b0;
    in_valid3  = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready",   32'(in_ready),   0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 0);
    checkOutput("rst_tx_req",     32'(tx_req),     0);
    checkOutput("rst_busy",       32'(busy),       0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);
  endtask

  // Offer one word at a negedge and return at the negedge after it is accepted.
  task automatic applyStimulus(input logic [DW-1:0] d);
    int t;
    t        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("push_accept", 32'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic waitIdle(input int max_cycles);
    int t;
    t = 0;
    while (busy && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_busy", 32'(busy), 0);
  endtask

  // Directed scenarios.
  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_data3   = '0;
    in_valid3  = 1'b0;
    tx_ack3    = 1'b0;
    manual_ack = 1'b0;
    loop_en    = 1'b0;

    // Single word with a looped-back ack.
    resetDut();
    loop_en = 1'b1;
    rx_q.delete();
    applyStimulus(8'hA5);
    in_valid = 1'b0;
    checkOutput("t1_count_after_push", 32'(fifo_count), 1);
    checkOutput("t1_req_before_launch", 32'(tx_req), 0);
    @(negedge clk);
    checkOutput("t1_req_launched", 32'(tx_req), 1);
    checkOutput("t1_data_launched", 32'(tx_data), 'hA5);
    waitIdle(50);
    checkOutput("t1_data_held", 32'(tx_data), 'hA5);
    checkOutput("t1_count_end", 32'(fifo_count), 0);
    checkOutput("t1_rx_words", 32'(rx_q.size()), 1);

    // Fill the FIFO while the ack is held, then toggle the ack once.
    resetDut();
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    in_valid = 1'b0;
    checkOutput("t2_full_ready", 32'(in_ready), 0);
    checkOutput("t2_full_count", 32'(fifo_count), 4);
    checkOutput("t2_first_data", 32'(tx_data), 'h01);
    checkOutput("t2_first_req", 32'(tx_req), 1);
    manual_ack = 1'b1;
    @(negedge clk);
    checkOutput("t2_req_not_yet", 32'(tx_req), 1);
    @(negedge clk);
    checkOutput("t2_req_second", 32'(tx_req), 0);
    checkOutput("t2_data_second", 32'(tx_data), 'h02);
    checkOutput("t2_count_after", 32'(fifo_count), 3);
    checkOutput("t2_ready_after", 32'(in_ready), 1);
    loop_en = 1'b1;
    waitIdle(200);

    // Continuous stream with the auto-ack receiver.
    resetDut();
    loop_en = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i));
    in_valid = 1'b0;
    waitIdle(300);
    checkOutput("t3_rx_count", 32'(rx_q.size()), 16);
    for (int i = 0; i < 16; i++) checkOutput("t3_rx_word", 32'(rx_q[i]), 32'(8'h10 + i));
    checkOutput("t3_req_end", 32'(tx_req), 0);
    checkOutput("t3_proto", 32'(proto_err), 0);

    // Unsolicited ack toggle while idle.
    manual_ack = 1'b0;
    loop_en    = 1'b0;
    @(negedge clk);
    manual_ack = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    checkOutput("t4_proto_set", 32'(proto_err), 1);
    loop_en = 1'b1;
    rx_q.delete();
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    in_valid = 1'b0;
    waitIdle(100);
    checkOutput("t4_proto_sticky", 32'(proto_err), 1);
    checkOutput("t4_rx_count", 32'(rx_q.size()), 2);
    checkOutput("t4_rx_last", 32'(rx_q[1]), 'h66);

    // Reset in the middle of a transfer with three words queued.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hC0 + i));
    in_valid = 1'b0;
    checkOutput("t5_count_before", 32'(fifo_count), 3);
    checkOutput("t5_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_count_rst", 32'(fifo_count), 0);
    checkOutput("t5_req_rst", 32'(tx_req), 0);
    checkOutput("t5_data_rst", 32'(tx_data), 0);
    checkOutput("t5_busy_rst", 32'(busy), 0);
    checkOutput("t5_proto_rst", 32'(proto_err), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    loop_en = 1'b1;
    rx_q.delete();
    applyStimulus(8'h7E);
    in_valid = 1'b0;
    waitIdle(50);
    checkOutput("t5_rx_count", 32'(rx_q.size()), 1);
    checkOutput("t5_rx_word", 32'(rx_q[0]), 'h7E);

    // Three-stage synchroniser: completion lands exactly two edges after the sampling edge.
    resetDut();
    in_data3  = 8'h3C;
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    @(negedge clk);
    checkOutput("t6_req", 32'(tx_req3), 1);
    checkOutput("t6_data", 32'(tx_data3), 'h3C);
    repeat (2) @(negedge clk);
    checkOutput("t6_busy_wait", 32'(busy3), 1);
    tx_ack3 = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy_k", 32'(busy3), 1);
    @(negedge clk);
    checkOutput("t6_busy_k1", 32'(busy3), 1);
    @(negedge clk);
    checkOutput("t6_busy_k2", 32'(busy3), 0);
    checkOutput("t6_count", 32'(fifo_count3), 0);
    checkOutput("t6_proto", 32'(proto_err3), 0);
    checkOutput("t6_ready", 32'(in_ready3), 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
